// File: rtl/bitwise_logic_unit.sv
// bitwise_logic_unit: multi-cycle bitwise AND/OR/XOR/NOR engine.
// Operands are captured on acceptance and processed SLICE bits per cycle.
// The result is held with a zero flag until the consumer takes it.
module bitwise_logic_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             zero
);

  // A guarded divisor keeps the derived constants computable even for an
  // illegal SLICE, so that the geometry check below reports the error.
  localparam int SLICE_G = (SLICE > 0) ? SLICE : 1;
  localparam int NSL     = (WIDTH > 0) ? (WIDTH / SLICE_G) : 1;
  localparam int KW      = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NSL - 1);

  // Reject any geometry where WIDTH is not a nonzero multiple of SLICE.
  if ((WIDTH <= 0) || (SLICE <= 0) || ((WIDTH % SLICE_G) != 0)) begin : g_bad_geometry
    $error("bitwise_logic_unit: WIDTH must be a nonzero multiple of SLICE");
  end

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e                       state;
  logic [KW-1:0]                k;
  logic                         nz;
  logic                         zero_q;
  op_e                          cop;
  logic [NSL-1:0][SLICE_G-1:0]  ca;
  logic [NSL-1:0][SLICE_G-1:0]  cb;
  logic [NSL-1:0][SLICE_G-1:0]  s_q;
  logic [SLICE_G-1:0]           sl_a;
  logic [SLICE_G-1:0]           sl_b;
  logic [SLICE_G-1:0]           res;

  // Handshake flags and result are straight decodes of registered state.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign s         = s_q;
  assign zero      = zero_q;

  // Operation result for the captured slice currently addressed by k.
  always_comb begin
    sl_a = ca[k];
    sl_b = cb[k];
    res  = '0;
    case (cop)
      OP_AND:  res = sl_a & sl_b;
      OP_OR:   res = sl_a | sl_b;
      OP_XOR:  res = sl_a ^ sl_b;
      OP_NOR:  res = ~(sl_a | sl_b);
      default: res = '0;
    endcase
  end

  // Control FSM and datapath: capture, per-slice write-back, result hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      s_q    <= '0;
      zero_q <= 1'b0;
      k      <= '0;
      nz     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ca    <= a;
            cb    <= b;
            cop   <= op_e'(op);
            k     <= '0;
            nz    <= 1'b0;
            state <= BUSY;
          end
        end
        BUSY: begin
          s_q[k] <= res;
          nz     <= nz | (|res);
          // k stops at the last slice so it never addresses past the operand.
          if (k == KLAST) begin
            zero_q <= ~(nz | (|res));
            state  <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bitwise_logic_unit.md
BITWISE_LOGIC_UNIT -- requirements
Module: bitwise_logic_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter SLICE, default 8, giving the bits processed per cycle; WIDTH SHALL be a nonzero multiple of SLICE, and any other value SHALL fail elaboration.
REQ-003 The block SHALL define the derived constant NSL = WIDTH/SLICE, the number of slices per operation.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: operands and op valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: block can accept an operation.
REQ-008 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-009 The block SHALL have port b, input, WIDTH bits: operand B.
REQ-010 The block SHALL have port op, input, 2 bits: operation select, 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-011 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-013 The block SHALL have port s, output, WIDTH bits: result.
REQ-014 The block SHALL have port zero, output, 1 bit: asserted when the whole result s is all zeros.

Function
REQ-015 The block SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; both SHALL be decoded from the state register.
REQ-017 In IDLE, when in_valid=1 the block SHALL, at that edge:
  - capture a, b and op into internal registers;
  - clear slice counter k to 0 and the accumulated nonzero flag nz to 0;
  - enter BUSY.
REQ-018 In BUSY, each edge SHALL:
  - write s[k*SLICE +: SLICE] with the op result of the captured slices;
  - set nz |= (that slice != 0);
  - increment k.
REQ-019 On the BUSY edge where k = NSL-1, the block SHALL write the final slice, load zero = ~(nz | final slice nonzero), and enter DONE.
REQ-020 Latency SHALL be exactly NSL cycles: out_valid SHALL rise NSL edges after the accepting edge (4 for the defaults; 1 when SLICE=WIDTH).
REQ-021 In DONE, s and zero SHALL hold stable; when out_ready=1 the block SHALL return to IDLE at that edge.
REQ-022 In DONE with out_ready=0, the block SHALL stall indefinitely with no change to any output.
REQ-023 Changes on a, b, op or in_valid while in BUSY or DONE SHALL be ignored; only captured values are used.
REQ-024 s bits not yet written in the current operation SHALL keep their previous value; s SHALL be fully defined only when out_valid=1.
REQ-025 Minimum throughput SHALL be one operation per NSL+2 cycles (accept, NSL-1 further BUSY edges, DONE handshake, IDLE).
REQ-026 NOR SHALL be the bitwise inverse of OR over each full slice; there are no carries or cross-slice dependencies.

Reset
REQ-027 When rst=1 at an edge, the block SHALL set state to IDLE, s to 0, zero to 0, k to 0 and nz to 0, regardless of current state.
REQ-028 After reset, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-029 Reset SHALL take priority over in_valid, out_ready and BUSY progress at the same edge.
REQ-030 An operation interrupted by reset SHALL be discarded and SHALL produce no out_valid.

Verification
REQ-031 A bench SHALL drive defaults, op=00, a=FFFF0000, b=0F0F0F0F, out_ready=1, and check s=0F0F0000, zero=0, with out_valid exactly 4 cycles after acceptance and held for 1 cycle.
REQ-032 A bench SHALL cover each op for a=A5A5A5A5, b=5A5A5A5A, and check OR=FFFFFFFF, XOR=FFFFFFFF, AND=00000000 with zero=1, and NOR=00000000 with zero=1.
REQ-033 A bench SHALL run an op with out_ready=0 for 10 cycles, and check that out_valid, s and zero stay constant, in_ready=0, and a new in_valid is ignored.
REQ-034 A bench SHALL change a, b and op every cycle during BUSY, and check that the result matches the values captured at acceptance.
REQ-035 A bench SHALL assert rst during the 2nd BUSY cycle, and check that the next cycle shows IDLE, in_ready=1, s=0, zero=0, and that no out_valid appears.
REQ-036 A bench SHALL use WIDTH=16, SLICE=16 with op=10, a=1234, b=1234, and check that out_valid rises 1 cycle after acceptance with s=0000, zero=1.
